// File: rtl/ex_operand_b_stage.sv
// EX-stage operand B select: forwarding mux, immediate extension and the
// registered operand/store-data/valid slot with a sticky reserved-select flag.
module ex_operand_b_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_regb,
  input  logic [DATA_WIDTH-1:0] i_fwd_mem,
  input  logic [DATA_WIDTH-1:0] i_fwd_wb,
  input  logic [1:0]            i_fwd_sel,
  input  logic [IMM_WIDTH-1:0]  i_imm,
  input  logic [1:0]            i_ext_mode,
  input  logic                  i_alusrc,
  output logic [DATA_WIDTH-1:0] o_datoBAlu,
  output logic [DATA_WIDTH-1:0] o_store_data,
  output logic                  o_valid,
  output logic                  o_sel_err
);

  localparam int PAD_WIDTH = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] w_fwd;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_shamt;
  logic [DATA_WIDTH-1:0] w_operand_b;
  logic                  w_load;

  logic [DATA_WIDTH-1:0] r_dato_b;
  logic [DATA_WIDTH-1:0] r_store_data;
  logic                  r_valid;
  logic                  r_sel_err;

  // Reserved select 11 falls back to the register-file value.
  always_comb begin
    w_fwd = i_regb;
    case (i_fwd_sel)
      2'b01:   w_fwd = i_fwd_mem;
      2'b10:   w_fwd = i_fwd_wb;
      default: w_fwd = i_regb;
    endcase
  end

  generate
    if (IMM_WIDTH >= 11) begin : g_shamt_field
      assign w_shamt = {{(DATA_WIDTH-5){1'b0}}, i_imm[10:6]};
    end else begin : g_shamt_narrow
      assign w_shamt = {{PAD_WIDTH{1'b0}}, i_imm};
    end
  endgenerate

  always_comb begin
    w_ext = {{PAD_WIDTH{1'b0}}, i_imm};
    case (i_ext_mode)
      2'b00:   w_ext = {{PAD_WIDTH{i_imm[IMM_WIDTH-1]}}, i_imm};
      2'b01:   w_ext = {{PAD_WIDTH{1'b0}}, i_imm};
      2'b10:   w_ext = {i_imm, {PAD_WIDTH{1'b0}}};
      default: w_ext = w_shamt;
    endcase
  end

  assign w_operand_b = i_alusrc ? w_ext : w_fwd;
  assign w_load      = !i_flush && !i_stall;

  // Flush outranks stall; data registers load even for invalid slots.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_dato_b     <= '0;
      r_store_data <= '0;
      r_valid      <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      if (i_flush) begin
        r_dato_b     <= '0;
        r_store_data <= '0;
        r_valid      <= 1'b0;
      end else if (!i_stall) begin
        r_dato_b     <= w_operand_b;
        r_store_data <= w_fwd;
        r_valid      <= i_valid;
      end
      if (w_load && i_valid && (i_fwd_sel == 2'b11)) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign o_datoBAlu   = r_dato_b;
  assign o_store_data = r_store_data;
  assign o_valid      = r_valid;
  assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_ex_operand_b_stage.sv
// Directed plus randomized bench for ex_operand_b_stage, checked against a
// behavioural slot model built from the operand/forwarding rules.
module tb_ex_operand_b_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid, alusrc;
  logic [31:0] regb, fwd_mem, fwd_wb;
  logic [1:0]  fwd_sel, ext_mode;
  logic [15:0] imm;
  logic [31:0] o_b, o_st;
  logic        o_v, o_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_b, m_st;
  logic        m_v, m_err;

  always #5 clk = ~clk;

  ex_operand_b_stage #(.DATA_WIDTH(32), .IMM_WIDTH(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_regb(regb), .i_fwd_mem(fwd_mem), .i_fwd_wb(fwd_wb),
    .i_fwd_sel(fwd_sel), .i_imm(imm), .i_ext_mode(ext_mode), .i_alusrc(alusrc),
    .o_datoBAlu(o_b), .o_store_data(o_st), .o_valid(o_v), .o_sel_err(o_err)
  );

  function automatic logic [31:0] ext_of(input logic [15:0] im, input logic [1:0] md);
    logic signed [31:0] s;
    case (md)
      2'd0: begin s = $signed(im); return s; end
      2'd1: return 32'(im);
      2'd2: return 32'(im) * 32'd65536;
      default: return (32'(im) / 32'd64) % 32'd32;
    endcase
  endfunction

  function automatic logic [31:0] fwd_of();
    if (fwd_sel == 2'd1) return fwd_mem;
    if (fwd_sel == 2'd2) return fwd_wb;
    return regb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_b"},   o_b,         m_b);
    check({tag, "_st"},  o_st,        m_st);
    check({tag, "_v"},   32'(o_v),    32'(m_v));
    check({tag, "_err"}, 32'(o_err),  32'(m_err));
  endtask

  // One clock edge: evaluate the model from the current inputs, then compare.
  task automatic tick(input string tag);
    logic [31:0] nb, nst;
    logic        nv, nerr;
    nb = m_b; nst = m_st; nv = m_v; nerr = m_err;
    if (flush) begin
      nb = 0; nst = 0; nv = 0;
    end else if (!stall) begin
      nst = fwd_of();
      nb  = alusrc ? ext_of(imm, ext_mode) : nst;
      nv  = valid;
      if (valid && fwd_sel == 2'd3) nerr = 1'b1;
    end
    @(posedge clk);
    #1;
    m_b = nb; m_st = nst; m_v = nv; m_err = nerr;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [1:0] sel, input logic as,
                        input logic [15:0] im, input logic [1:0] md,
                        input logic [31:0] rb, input logic [31:0] fm, input logic [31:0] fw);
    valid = v; fwd_sel = sel; alusrc = as; imm = im; ext_mode = md;
    regb = rb; fwd_mem = fm; fwd_wb = fw;
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0;
    set_in(0, 2'd0, 0, 16'h0, 2'd0, 32'h0, 32'h0, 32'h0);
    m_b = 0; m_st = 0; m_v = 0; m_err = 0;
    #12;
    check_all("reset");
    rst = 1'b0;

    // Immediate extension modes
    set_in(1, 2'd0, 1, 16'h8001, 2'd0, 32'h1, 32'h2, 32'h3);
    tick("sign");
    check("sign_lit", o_b, 32'hFFFF8001);
    ext_mode = 2'd1; tick("zero");
    check("zero_lit", o_b, 32'h00008001);
    ext_mode = 2'd2; tick("upper");
    check("upper_lit", o_b, 32'h80010000);
    imm = 16'h07C0; ext_mode = 2'd3; tick("shamt");
    check("shamt_lit", o_b, 32'h0000001F);

    // Forwarding
    set_in(1, 2'd1, 0, 16'h1234, 2'd0, 32'h1, 32'hDEADBEEF, 32'h5);
    tick("fwd_mem");
    check("fwd_mem_lit", o_st, 32'hDEADBEEF);
    fwd_sel = 2'd2; tick("fwd_wb");
    check("fwd_wb_lit", o_b, 32'h5);

    // Stall hold, then flush over stall
    set_in(1, 2'd0, 0, 16'h0, 2'd0, 32'hA, 32'h0, 32'h0);
    tick("load_a");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      regb = $urandom; imm = 16'($urandom); alusrc = 1'($urandom);
      tick("stall_hold");
      check("stall_lit", o_b, 32'hA);
    end
    flush = 1; tick("stall_flush");
    flush = 0; stall = 0;

    // Reserved select must not latch unless the slot actually loads
    set_in(1, 2'd3, 0, 16'h0, 2'd0, 32'h77, 32'h0, 32'h0);
    stall = 1; tick("sel11_stall");
    check("sel11_stall_lit", 32'(o_err), 32'h0);
    stall = 0; flush = 1; tick("sel11_flush");
    flush = 0; valid = 0; tick("sel11_invalid");
    valid = 1; tick("sel11_load");
    check("sel11_lit", 32'(o_err), 32'h1);
    fwd_sel = 2'd0; tick("sel11_sticky");

    // Async reset between edges while a valid slot is held
    set_in(1, 2'd0, 0, 16'h0, 2'd0, 32'h55, 32'h0, 32'h0);
    tick("pre_reset");
    stall = 1;
    #2 rst = 1'b1;
    #1;
    m_b = 0; m_st = 0; m_v = 0; m_err = 0;
    check_all("async_reset");
    #1 rst = 1'b0;
    stall = 0; tick("post_reset");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_b_stage.md
EX_OPERAND_B_STAGE -- requirements
Module: ex_operand_b_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of datapath words.
REQ-002 SHALL have parameter IMM_WIDTH, default 16, width of raw immediate field; legal range 6..DATA_WIDTH-1.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have these ports:
- i_stall  in  1  hold all output registers.
- i_flush  in  1  insert bubble.
- i_valid  in  1  upstream (ID/EX) slot carries a real instruction.
- i_regb  in  DATA_WIDTH  register-file rt value.
- i_fwd_mem  in  DATA_WIDTH  EX/MEM result for forwarding.
- i_fwd_wb  in  DATA_WIDTH  MEM/WB result for forwarding.
- i_fwd_sel  in  2  00 regb, 01 mem, 10 wb, 11 reserved.
- i_imm  in  IMM_WIDTH  raw immediate.
- i_ext_mode  in  2  00 sign, 01 zero, 10 upper, 11 shamt.
- i_alusrc  in  1  1 = immediate operand, 0 = forwarded register.
- o_datoBAlu  out  DATA_WIDTH  registered ALU operand B.
- o_store_data  out  DATA_WIDTH  registered forwarded rt value, for stores.
- o_valid  out  1  registered slot valid.
- o_sel_err  out  1  sticky reserved-select flag.

Function
REQ-005 Forwarded value fwd SHALL be i_regb for sel 00 and 11, i_fwd_mem for 01, i_fwd_wb for 10.
REQ-006 Extended immediate ext SHALL be computed per i_ext_mode:
- sign: i_imm[IMM_WIDTH-1] replicated to DATA_WIDTH.
- zero: zero-padded to DATA_WIDTH.
- upper: i_imm placed in bits [DATA_WIDTH-1 : DATA_WIDTH-IMM_WIDTH], lower bits 0.
- shamt: i_imm[10:6] zero-extended when IMM_WIDTH>=11, else i_imm[IMM_WIDTH-1:0] zero-extended.
REQ-007 Operand B SHALL be ext when i_alusrc=1, else fwd.
REQ-008 Latency SHALL be exactly 1 cycle: inputs sampled at clock edge N appear on the outputs after edge N.
REQ-009 On an edge with i_flush=1, o_valid SHALL become 0 and o_datoBAlu and o_store_data SHALL become 0.
REQ-010 On an edge with i_stall=1 and i_flush=0, all outputs SHALL hold their values.
REQ-011 i_flush SHALL take priority over i_stall when both are asserted.
REQ-012 On an edge with neither i_stall nor i_flush: o_valid<=i_valid, o_datoBAlu<=operand B, o_store_data<=fwd.
REQ-013 When i_valid=0 and the slot is loaded, the data registers SHALL still load computed values; consumers ignore them via o_valid=0.
REQ-014 o_sel_err SHALL set on any loading edge (no stall, no flush) where i_valid=1 and i_fwd_sel=11, and SHALL clear only on reset.
REQ-015 o_sel_err SHALL NOT set when the sel 11 slot is stalled, flushed, or invalid.
REQ-016 No combinational path SHALL exist from any input to any output.

Reset
REQ-017 While i_reset=1, regardless of clock, o_datoBAlu=0, o_store_data=0, o_valid=0, o_sel_err=0.
REQ-018 Reset asserted mid-stall SHALL clear all outputs immediately; the first edge after deassertion SHALL follow REQ-009..REQ-012.

Verification
REQ-019 The bench SHALL cover these directed scenarios (DATA_WIDTH=32, IMM_WIDTH=16):
- imm=16'h8001, mode=sign, alusrc=1, valid=1 -> next cycle o_datoBAlu=32'hFFFF8001, o_valid=1.
- imm=16'h8001, mode=zero -> 32'h00008001; mode=upper -> 32'h80010000; imm=16'h07C0, mode=shamt -> 32'h0000001F.
- alusrc=0, sel=01, fwd_mem=32'hDEADBEEF, regb=32'h1 -> o_datoBAlu=o_store_data=32'hDEADBEEF; sel=10, fwd_wb=32'h5 -> 32'h5.
- Load 32'hA, then stall=1 for 3 cycles with changing inputs -> outputs stay 32'hA; stall=1 and flush=1 together -> o_valid=0, data 0.
- valid=1, sel=11 -> o_sel_err=1 and stays 1 after sel returns to 00; the same stimulus with stall=1 -> o_sel_err stays 0.
- Assert i_reset between clock edges while o_valid=1 -> all outputs 0 before the next edge.
